// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings for the pipeline hazard controller
package hazard_pkg;

  // MDU sequencer state encoding
  localparam logic [1:0] MDU_IDLE  = 2'd0;
  localparam logic [1:0] MDU_BUSY  = 2'd1;
  localparam logic [1:0] MDU_DRAIN = 2'd2;

  // E-stage ALU operand source selects
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

endpackage

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - start/done sequencer for the multi-cycle multiply/divide unit
module mdu_seq
  import hazard_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic mdu_op_e,
  input  logic mdu_done,
  output logic mstall,
  output logic mdu_go,
  output logic mdu_busy
);

  logic [1:0] state;
  logic [1:0] state_n;

  // Next state: start on an op, wait for done, then one DRAIN cycle so the
  // finished op can leave E without being launched a second time.
  always_comb begin
    state_n = state;
    case (state)
      MDU_IDLE:  if (mdu_op_e) state_n = MDU_BUSY;
      MDU_BUSY:  if (mdu_done) state_n = MDU_DRAIN;
      MDU_DRAIN: state_n = MDU_IDLE;
      default:   state_n = MDU_IDLE;
    endcase
  end

  // State register; reset aborts any sequence in flight with no DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MDU_IDLE;
    else     state <= state_n;
  end

  // Mealy start pulse and stall; both held low while reset is asserted.
  always_comb begin
    mdu_go   = !rst && (state == MDU_IDLE) && mdu_op_e;
    mstall   = !rst && (((state == MDU_IDLE) && mdu_op_e) || (state == MDU_BUSY));
    mdu_busy = (state == MDU_BUSY);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forwarding control for the 5-stage pipeline (optional HAZARD_PERF_EN stall counter)
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REGW = 5,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REGW-1:0] rs_d,
  input  logic [REGW-1:0] rt_d,
  input  logic [REGW-1:0] rs_e,
  input  logic [REGW-1:0] rt_e,
  input  logic [REGW-1:0] writereg_e,
  input  logic [REGW-1:0] writereg_m,
  input  logic [REGW-1:0] writereg_w,
  input  logic            regwrite_e,
  input  logic            regwrite_m,
  input  logic            regwrite_w,
  input  logic            memtoreg_e,
  input  logic            memtoreg_m,
  input  logic            branch_d,
  input  logic            pcsrc_d,
  input  logic            mdu_op_e,
  input  logic            mdu_done,
  output logic            stall_f,
  output logic            stall_d,
  output logic            stall_e,
  output logic            flush_d,
  output logic            flush_e,
  output logic            flush_m,
  output logic            fwd_a_d,
  output logic            fwd_b_d,
  output logic [1:0]      fwd_a_e,
  output logic [1:0]      fwd_b_e,
  output logic            mdu_go,
`ifdef HAZARD_PERF_EN
  output logic [CNTW-1:0] stall_cnt,
`endif
  output logic            mdu_busy
);

  logic mstall;
  logic lwstall;
  logic brstall;

  // Register 0 is hardwired, so it never carries a dependency.
  function automatic logic hit(input logic [REGW-1:0] a, input logic [REGW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  mdu_seq u_mdu_seq (
    .clk      (clk),
    .rst      (rst),
    .mdu_op_e (mdu_op_e),
    .mdu_done (mdu_done),
    .mstall   (mstall),
    .mdu_go   (mdu_go),
    .mdu_busy (mdu_busy)
  );

  // Forwarding selects; the younger M result wins over W.
  always_comb begin
    fwd_a_e = FWD_NONE;
    fwd_b_e = FWD_NONE;
    if (regwrite_m && hit(writereg_m, rs_e))      fwd_a_e = FWD_M;
    else if (regwrite_w && hit(writereg_w, rs_e)) fwd_a_e = FWD_W;
    if (regwrite_m && hit(writereg_m, rt_e))      fwd_b_e = FWD_M;
    else if (regwrite_w && hit(writereg_w, rt_e)) fwd_b_e = FWD_W;
    fwd_a_d = regwrite_m && hit(writereg_m, rs_d);
    fwd_b_d = regwrite_m && hit(writereg_m, rt_d);
  end

  // Stall and flush; an MDU stall freezes E, so it suppresses the E bubble.
  always_comb begin
    lwstall = memtoreg_e && (hit(writereg_e, rs_d) || hit(writereg_e, rt_d));
    brstall = branch_d &&
              ((regwrite_e && (hit(writereg_e, rs_d) || hit(writereg_e, rt_d))) ||
               (memtoreg_m && (hit(writereg_m, rs_d) || hit(writereg_m, rt_d))));
    stall_f = lwstall || brstall || mstall;
    stall_d = stall_f;
    stall_e = mstall;
    flush_m = mstall;
    flush_e = (lwstall || brstall) && !mstall;
    flush_d = pcsrc_d && !stall_f;
  end

`ifdef HAZARD_PERF_EN
  // Saturating count of cycles in which fetch is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           stall_cnt <= '0;
    else if (stall_f && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end
`else
  logic unused_cnt_cfg;
  assign unused_cnt_cfg = (CNTW > 0);
`endif

endmodule
